// File: rtl/fifo_sc_thr_if.sv
// Stream handshake bundle for fifo_sc_thr: the producer/consumer side is the
// master, the FIFO itself is the slave.
interface fifo_sc_thr_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
);
  logic [DWIDTH-1:0] data_i;
  logic              wrreq_i;
  logic              rdreq_i;
  logic [DWIDTH-1:0] q_o;
  logic              empty_o;
  logic              full_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [AWIDTH:0]   usedw_o;
  logic              ovf_o;
  logic              udf_o;

  modport master (
    output data_i, wrreq_i, rdreq_i,
    input  q_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o, ovf_o, udf_o
  );

  modport slave (
    input  data_i, wrreq_i, rdreq_i,
    output q_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o, ovf_o, udf_o
  );
endinterface

// File: rtl/fifo_sc_thr.sv
// Single-clock FIFO with show-ahead/normal read mode, fill counter,
// programmable almost-full/almost-empty thresholds and overflow/underflow strobes.
module fifo_sc_thr #(
  parameter int    DWIDTH       = 8,
  parameter int    AWIDTH       = 3,
  parameter string SHOWAHEAD    = "ON",
  parameter int    ALMOST_FULL  = 6,
  parameter int    ALMOST_EMPTY = 2
) (
  input  logic           clk_i,
  input  logic           arst_i,
  input  logic           srst_i,
  fifo_sc_thr_if.slave   bus
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam bit SHOW_ON = (SHOWAHEAD == "ON");
  localparam bit AEMPTY_RST = (ALMOST_EMPTY > 0);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1'b1);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH + 1)'(1'b1);
  localparam logic [AWIDTH:0] CNT_ZERO = (AWIDTH + 1)'(1'b0);
  localparam logic [AWIDTH:0] CNT_FULL = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] CNT_AFULL = (AWIDTH + 1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] CNT_AEMPTY = (AWIDTH + 1)'(ALMOST_EMPTY);

  generate
    if (!((ALMOST_EMPTY > 0) && (ALMOST_EMPTY <= ALMOST_FULL) && (ALMOST_FULL <= DEPTH))) begin : g_bad_thr
      $error("fifo_sc_thr: need 0 < ALMOST_EMPTY <= ALMOST_FULL <= DEPTH");
    end
    if ((SHOWAHEAD != "ON") && (SHOWAHEAD != "OFF")) begin : g_bad_mode
      $error("fifo_sc_thr: SHOWAHEAD must be \"ON\" or \"OFF\"");
    end
  endgenerate

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_r;
  logic [AWIDTH-1:0] rd_ptr_r;
  logic [AWIDTH:0]   usedw_r;
  logic              empty_r;
  logic              full_r;
  logic              afull_r;
  logic              aempty_r;
  logic              ovf_r;
  logic              udf_r;
  logic [DWIDTH-1:0] q_r;

  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [AWIDTH-1:0] wr_ptr_nxt_s;
  logic [AWIDTH-1:0] rd_ptr_nxt_s;
  logic [AWIDTH:0]   usedw_nxt_s;
  logic [DWIDTH-1:0] q_nxt_s;

  // Acceptance, next pointers/count and next output word
  always_comb begin
    rd_acc_s     = bus.rdreq_i & ~empty_r;
    wr_acc_s     = bus.wrreq_i & (~full_r | rd_acc_s);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    usedw_nxt_s  = usedw_r;
    q_nxt_s      = q_r;

    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   usedw_nxt_s = usedw_r + CNT_ONE;
      2'b01:   usedw_nxt_s = usedw_r - CNT_ONE;
      default: usedw_nxt_s = usedw_r;
    endcase

    // Show-ahead tracks the next head, bypassing the RAM when it is being written now
    if (SHOW_ON) begin
      if (wr_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
        q_nxt_s = bus.data_i;
      end else begin
        q_nxt_s = mem_r[rd_ptr_nxt_s];
      end
    end else if (rd_acc_s) begin
      q_nxt_s = mem_r[rd_ptr_r];
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= bus.data_i;
    end
  end

  // Pointers, fill count, flags, strobes and output word
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      usedw_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      aempty_r <= AEMPTY_RST;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      q_r      <= '0;
    end else if (srst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      usedw_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      aempty_r <= AEMPTY_RST;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      q_r      <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      usedw_r  <= usedw_nxt_s;
      empty_r  <= (usedw_nxt_s == CNT_ZERO);
      full_r   <= (usedw_nxt_s == CNT_FULL);
      afull_r  <= (usedw_nxt_s >= CNT_AFULL);
      aempty_r <= (usedw_nxt_s < CNT_AEMPTY);
      ovf_r    <= bus.wrreq_i & ~wr_acc_s;
      udf_r    <= bus.rdreq_i & ~rd_acc_s;
      q_r      <= q_nxt_s;
    end
  end

  assign bus.q_o            = q_r;
  assign bus.empty_o        = empty_r;
  assign bus.full_o         = full_r;
  assign bus.almost_full_o  = afull_r;
  assign bus.almost_empty_o = aempty_r;
  assign bus.usedw_o        = usedw_r;
  assign bus.ovf_o          = ovf_r;
  assign bus.udf_o          = udf_r;

endmodule

// File: tb/tb_fifo_sc_thr.sv
// Bench for fifo_sc_thr: one show-ahead and one normal-mode instance share the
// same stimulus and are checked against a queue-based reference model.
module tb_fifo_sc_thr;

  logic       clk;
  logic       arst;
  logic       srst;
  logic       wr_s;
  logic       rd_s;
  logic [7:0] d_s;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  int         cnt      = 0;
  logic [7:0] qoff_mdl = 8'h00;
  bit         exp_ovf  = 1'b0;
  bit         exp_udf  = 1'b0;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] d;
    logic [3:0] usedw;
    bit         ovf;
    bit         udf;
  } vec_t;
  vec_t vt[18];

  fifo_sc_thr_if #(.DWIDTH(8), .AWIDTH(3)) bus_on ();
  fifo_sc_thr_if #(.DWIDTH(8), .AWIDTH(3)) bus_off ();

  assign bus_on.data_i   = d_s;
  assign bus_on.wrreq_i  = wr_s;
  assign bus_on.rdreq_i  = rd_s;
  assign bus_off.data_i  = d_s;
  assign bus_off.wrreq_i = wr_s;
  assign bus_off.rdreq_i = rd_s;

  fifo_sc_thr #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("ON"), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) u_on (
    .clk_i (clk), .arst_i (arst), .srst_i (srst), .bus (bus_on)
  );

  fifo_sc_thr #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("OFF"), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) u_off (
    .clk_i (clk), .arst_i (arst), .srst_i (srst), .bus (bus_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    sb_q.delete();
    cnt      = 0;
    qoff_mdl = 8'h00;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_on_usedw"},  {28'h0, bus_on.usedw_o},  cnt);
    chk({tag, "_on_empty"},  {31'h0, bus_on.empty_o},  {31'h0, cnt == 0});
    chk({tag, "_on_full"},   {31'h0, bus_on.full_o},   {31'h0, cnt == 8});
    chk({tag, "_on_afull"},  {31'h0, bus_on.almost_full_o},  {31'h0, cnt >= 6});
    chk({tag, "_on_aempty"}, {31'h0, bus_on.almost_empty_o}, {31'h0, cnt < 2});
    chk({tag, "_on_ovf"},    {31'h0, bus_on.ovf_o},    {31'h0, exp_ovf});
    chk({tag, "_on_udf"},    {31'h0, bus_on.udf_o},    {31'h0, exp_udf});
    chk({tag, "_off_usedw"}, {28'h0, bus_off.usedw_o}, cnt);
    chk({tag, "_off_empty"}, {31'h0, bus_off.empty_o}, {31'h0, cnt == 0});
    chk({tag, "_off_full"},  {31'h0, bus_off.full_o},  {31'h0, cnt == 8});
    chk({tag, "_off_ovf"},   {31'h0, bus_off.ovf_o},   {31'h0, exp_ovf});
    chk({tag, "_off_udf"},   {31'h0, bus_off.udf_o},   {31'h0, exp_udf});
    chk({tag, "_off_q"},     {24'h0, bus_off.q_o},     {24'h0, qoff_mdl});
    if (cnt > 0) begin
      chk({tag, "_on_head"}, {24'h0, bus_on.q_o}, {24'h0, sb_q[0]});
    end
  endtask

  // One clock of stimulus; the model predicts the state after the edge
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit s, input string tag);
    bit         rd_ok;
    bit         wr_ok;
    logic [7:0] head;
    wr_s = w;
    rd_s = r;
    d_s  = d;
    srst = s;
    if (s) begin
      mdl_reset();
    end else begin
      rd_ok = r && (cnt > 0);
      wr_ok = w && ((cnt < 8) || rd_ok);
      if (rd_ok) begin
        head     = sb_q.pop_front();
        qoff_mdl = head;
      end
      if (wr_ok) sb_q.push_back(d);
      cnt     = cnt + int'(wr_ok) - int'(rd_ok);
      exp_ovf = w && !wr_ok;
      exp_udf = r && !rd_ok;
    end
    @(posedge clk);
    #1;
    wr_s = 1'b0;
    rd_s = 1'b0;
    srst = 1'b0;
    chk_flags(tag);
    if (s) chk({tag, "_on_q_srst"}, {24'h0, bus_on.q_o}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{wr: 1'b1, rd: 1'b0, d: 8'(i + 1), usedw: 4'(i + 1), ovf: 1'b0, udf: 1'b0};
    end
    vt[8] = '{wr: 1'b1, rd: 1'b0, d: 8'hFF, usedw: 4'd8, ovf: 1'b1, udf: 1'b0};
    for (int i = 0; i < 8; i++) begin
      vt[9 + i] = '{wr: 1'b0, rd: 1'b1, d: 8'h00, usedw: 4'(7 - i), ovf: 1'b0, udf: 1'b0};
    end
    vt[17] = '{wr: 1'b0, rd: 1'b1, d: 8'h00, usedw: 4'd0, ovf: 1'b0, udf: 1'b1};

    arst = 1'b1;
    srst = 1'b0;
    wr_s = 1'b0;
    rd_s = 1'b0;
    d_s  = 8'h00;
    #12;
    mdl_reset();
    chk_flags("rst");
    chk("rst_on_q", {24'h0, bus_on.q_o}, 32'h0);
    #1 arst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, overflow, drain in order, underflow
    for (int i = 0; i < 18; i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].d, 1'b0, "tbl");
      chk("tbl_usedw", {28'h0, bus_on.usedw_o}, {28'h0, vt[i].usedw});
      chk("tbl_ovf",   {31'h0, bus_on.ovf_o},   {31'h0, vt[i].ovf});
      chk("tbl_udf",   {31'h0, bus_on.udf_o},   {31'h0, vt[i].udf});
    end

    // Normal-mode read latency and hold
    step(1'b1, 1'b0, 8'hA5, 1'b0, "t3w1");
    step(1'b1, 1'b0, 8'h5A, 1'b0, "t3w2");
    step(1'b0, 1'b1, 8'h00, 1'b0, "t3r1");
    chk("t3_q_first", {24'h0, bus_off.q_o}, 32'hA5);
    step(1'b0, 1'b1, 8'h00, 1'b0, "t3r2");
    chk("t3_q_second", {24'h0, bus_off.q_o}, 32'h5A);
    step(1'b0, 1'b0, 8'h00, 1'b0, "t3idle");
    step(1'b0, 1'b1, 8'h00, 1'b0, "t3udf");
    chk("t3_q_hold", {24'h0, bus_off.q_o}, 32'h5A);

    // Full with simultaneous read/write, across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, "t4fill");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, "t4rw");
      chk("t4_usedw", {28'h0, bus_on.usedw_o}, 32'd8);
      chk("t4_noovf", {31'h0, bus_on.ovf_o}, 32'd0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "t4drain");

    // Empty with simultaneous read/write
    step(1'b1, 1'b1, 8'h33, 1'b0, "t5");
    chk("t5_usedw", {28'h0, bus_on.usedw_o}, 32'd1);
    chk("t5_udf",   {31'h0, bus_on.udf_o},   32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, "t5idle");
    chk("t5_q_on",  {24'h0, bus_on.q_o},     32'h33);
    step(1'b0, 1'b1, 8'h00, 1'b0, "t5drain");

    // Asynchronous reset mid-clock, then synchronous clear
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, "t6fill");
    chk("t6_usedw5", {28'h0, bus_on.usedw_o}, 32'd5);
    #2 arst = 1'b1;
    #1;
    mdl_reset();
    chk_flags("t6arst");
    chk("t6_arst_on_q", {24'h0, bus_on.q_o}, 32'h0);
    #2 arst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, "t6refill");
    step(1'b1, 1'b0, 8'hEE, 1'b1, "t6srst");
    step(1'b1, 1'b0, 8'h77, 1'b0, "t6w");
    chk("t6_on_q", {24'h0, bus_on.q_o}, 32'h77);
    step(1'b0, 1'b1, 8'h00, 1'b0, "t6r");
    chk("t6_off_q", {24'h0, bus_off.q_o}, 32'h77);
    chk("t6_empty", {31'h0, bus_on.empty_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
